tt_um_count_checker: RTL and testbench

TT_UM_COUNT_CHECKER -- requirements
Module: tt_um_count_checker

---
 rtl/count_checker_pkg.sv | 24 ++
 rtl/count_checker_if.sv | 13 +
 rtl/count_checker_sat_cnt.sv | 21 ++
 rtl/tt_um_count_checker.sv | 136 +++++++++++++
 tb/tb_tt_um_count_checker.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_checker_pkg.sv
// Shared types and constants for the free-running counter checker.
// The state enumeration, state codes and the consecutive-mismatch limit are defined here.
package count_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  localparam logic [1:0] CODE_FAIL         = 2'b11;
  localparam int         CONSEC_FAIL_LIMIT = 4;
  localparam logic [2:0] CONSEC_LIMIT      = 3'(CONSEC_FAIL_LIMIT);

  // FAIL shares the 2'b11 code with HOLD; the fail bit next to it tells them apart.
  function automatic logic [1:0] state_code(input state_t st);
    logic [2:0] raw;
    raw = st;
    return (st == ST_FAIL) ? CODE_FAIL : raw[1:0];
  endfunction

endpackage

// File: rtl/count_checker_if.sv
// Pin bundle of the counter checker tile: observed count, control byte and outputs.
// master drives the stimulus side (counter under test plus control), slave is the checker.
interface count_checker_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, ena, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, ena, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/count_checker_sat_cnt.sv
// 8-bit up counter with synchronous clear and saturation at 8'hFF.
// Clear takes priority over a simultaneous increment.
module count_checker_sat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/tt_um_count_checker.sv
// Checks an external free-running counter: starts/stops it and compares each observed value.
// Optional wrap counter on view=1 is enabled by defining COUNT_CHECKER_WRAP_CNT_EN.
module tt_um_count_checker
  import count_checker_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic go, hold, clr, view;
  assign go   = uio_in[0];
  assign hold = uio_in[1];
  assign clr  = uio_in[2];
  assign view = uio_in[3];

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in[7:4]};

  state_t     state, state_nxt;
  logic       stop, stop_d1;
  logic [7:0] s;
  logic [2:0] consec, consec_nxt;
  logic       fail_flag;
  logic [7:0] err_cnt;
  logic [7:0] view_word;
  logic       cmp_en, mismatch, hit_limit;
  logic [7:0] expected;

  // stop_d1 records whether the counter advanced on the previous edge.
  assign cmp_en    = (state == ST_RUN) || (state == ST_HOLD);
  assign expected  = s + {7'd0, ~stop_d1};
  assign mismatch  = cmp_en && (ui_in != expected);
  assign hit_limit = mismatch && !clr && (consec_nxt == CONSEC_LIMIT);

  always_comb begin
    consec_nxt = consec;
    if (clr) begin
      consec_nxt = 3'd0;
    end else if (mismatch) begin
      consec_nxt = (consec == CONSEC_LIMIT) ? consec : consec + 3'd1;
    end else if (cmp_en) begin
      consec_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_SYNC;
      ST_SYNC: state_nxt = ST_RUN;
      ST_RUN: begin
        if (hit_limit)  state_nxt = ST_FAIL;
        else if (!go)   state_nxt = ST_IDLE;
        else if (hold)  state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hit_limit)  state_nxt = ST_FAIL;
        else if (!go)   state_nxt = ST_IDLE;
        else if (!hold) state_nxt = ST_RUN;
      end
      ST_FAIL: if (clr) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop      <= 1'b1;
      stop_d1   <= 1'b1;
      s         <= 8'h00;
      consec    <= 3'd0;
      fail_flag <= 1'b0;
    end else begin
      stop    <= (state_nxt != ST_RUN);
      stop_d1 <= stop;
      s       <= ui_in;
      consec  <= consec_nxt;
      if (clr) begin
        fail_flag <= 1'b0;
      end else if (mismatch) begin
        fail_flag <= 1'b1;
      end
    end
  end

  count_checker_sat_cnt u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (mismatch),
    .count (err_cnt)
  );

`ifdef COUNT_CHECKER_WRAP_CNT_EN
  logic [7:0] wrap_cnt;
  logic       wrap_step;

  // A matched FF->00 step while the counter is running counts as one wrap.
  assign wrap_step = (state == ST_RUN) && !stop_d1 && (s == 8'hFF) && (ui_in == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= 8'h00;
    end else if (clr) begin
      wrap_cnt <= 8'h00;
    end else if (wrap_step) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end

  assign view_word = wrap_cnt;
`else
  assign view_word = {fail_flag, state_code(state), consec, 2'b00};
`endif

  always_comb begin
    uio_out = {stop, fail_flag, state_code(state), 4'b0000};
    uo_out  = view ? view_word : err_cnt;
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Bench for tt_um_count_checker: an external counter model feeds ui_in, a behavioural checker
// model predicts outputs every cycle, and directed literals pin key points of each scenario.
module tb_tt_um_count_checker;

  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_RUN  = 2;
  localparam int M_HOLD = 3;
  localparam int M_FAIL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  count_checker_if bus();

  tt_um_count_checker dut (
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe),
    .ena     (bus.ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_mis = 0;
  logic       chk_on = 1'b0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic [7:0] cnt_c;
  logic [15:0] exp_q[$];

  assign bus.ena   = 1'b1;
  assign bus.ui_in = force_en ? force_val : cnt_c;

  // External counter under test, started/stopped by the checker's stop pin.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_c <= 8'h00;
    else if (!bus.uio_out[7]) cnt_c <= cnt_c + 8'd1;
  end

  // Behavioural model of the checker.
  int         m_mode, m_consec, t_nc;
  logic [7:0] m_prev, m_err, m_wraps, t_want;
  logic       m_ran, m_fail, t_go, t_hold, t_clr, t_cmp, t_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_consec <= 0; m_prev <= 8'h00; m_err <= 8'h00;
      m_wraps <= 8'h00; m_ran <= 1'b0; m_fail <= 1'b0;
    end else begin
      t_go   = bus.uio_in[0];
      t_hold = bus.uio_in[1];
      t_clr  = bus.uio_in[2];
      t_cmp  = (m_mode == M_RUN) || (m_mode == M_HOLD);
      t_want = m_prev + (m_ran ? 8'd1 : 8'd0);
      t_mis  = t_cmp && (bus.ui_in != t_want);
      if (t_clr)      t_nc = 0;
      else if (t_mis) t_nc = (m_consec < 4) ? m_consec + 1 : 4;
      else if (t_cmp) t_nc = 0;
      else            t_nc = m_consec;
      m_consec <= t_nc;
      m_err    <= t_clr ? 8'h00 : ((t_mis && m_err != 8'hFF) ? m_err + 8'd1 : m_err);
      m_fail   <= t_clr ? 1'b0 : (t_mis ? 1'b1 : m_fail);
      m_wraps  <= t_clr ? 8'h00 :
                  ((m_mode == M_RUN && m_ran && m_prev == 8'hFF && bus.ui_in == 8'h00) ?
                   m_wraps + 8'd1 : m_wraps);
      if (t_cmp && t_nc == 4) m_mode <= M_FAIL;
      else case (m_mode)
        M_IDLE: if (t_go) m_mode <= M_SYNC;
        M_SYNC: m_mode <= M_RUN;
        M_RUN:  if (!t_go) m_mode <= M_IDLE; else if (t_hold) m_mode <= M_HOLD;
        M_HOLD: if (!t_go) m_mode <= M_IDLE; else if (!t_hold) m_mode <= M_RUN;
        default: if (t_clr) m_mode <= M_IDLE;
      endcase
      m_prev <= bus.ui_in;
      m_ran  <= (m_mode == M_RUN);
    end
  end

  function automatic logic [1:0] m_code();
    return (m_mode == M_FAIL) ? 2'b11 : 2'(m_mode);
  endfunction

  function automatic logic [7:0] exp_uo();
    if (!bus.uio_in[3]) return m_err;
`ifdef COUNT_CHECKER_WRAP_CNT_EN
    return m_wraps;
`else
    return {m_fail, m_code(), 3'(m_consec), 2'b00};
`endif
  endfunction

  function automatic logic [7:0] exp_uio();
    return {(m_mode != M_RUN), m_fail, m_code(), 4'h0};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, want, $time);
    end
  endtask

  // Scoreboard: one expected snapshot per meaningful cycle, checked away from the clock edge.
  always @(negedge clk) begin
    logic [15:0] e;
    #2;
    if (chk_on && rst_n) begin
      exp_q.push_back({exp_uio(), exp_uo()});
      e = exp_q.pop_front();
      check("cyc_uio_out", bus.uio_out, e[15:8]);
      check("cyc_uo_out", bus.uo_out, e[7:0]);
      check("cyc_uio_oe", bus.uio_oe, 8'hF0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ctl(input logic go, input logic hold, input logic clr, input logic view);
    bus.uio_in = {4'h0, view, clr, hold, go};
  endtask

  int         stop_seen;
  logic [7:0] c_a, c_b;
  logic       found;

  initial begin
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(3);
    #1;
    check("reset_uo_out", bus.uo_out, 8'h00);
    check("reset_uio_out", bus.uio_out, 8'h80);
    check("reset_uio_oe", bus.uio_oe, 8'hF0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Long run: counter wraps once with no errors.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick(300);
    #1;
    check("run_uio_out", bus.uio_out, 8'h20);
    check("run_err_cnt", bus.uo_out, 8'h00);
    check("run_count_value", cnt_c, 8'd42);
`ifdef COUNT_CHECKER_WRAP_CNT_EN
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("run_wrap_cnt", bus.uo_out, 8'h01);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Hold for 5 cycles: stop high exactly that long, counter frozen.
    tick(1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    stop_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      #1;
      if (bus.uio_out[7]) stop_seen++;
      if (i == 0) begin
        c_a = cnt_c;
        check("hold_uio_out", bus.uio_out, 8'hB0);
      end
      if (i == 4) begin
        c_b = cnt_c;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    check("hold_stop_cycles", 8'(stop_seen), 8'd5);
    check("hold_frozen", c_b - c_a, 8'h00);
    check("hold_err_cnt", bus.uo_out, 8'h00);

    // Two forced 8'h55 samples while the counter passes 54/55.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1);
      if (cnt_c == 8'h54) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_mis++;
      $display("FAIL wait_count_54: got timeout, expected counter 54");
    end
    force_val = 8'h55;
    force_en = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    #1;
`ifndef COUNT_CHECKER_WRAP_CNT_EN
    check("force_view_c1", bus.uo_out, 8'hC4);
`endif
    tick(1);
    force_en = 1'b0;
    #1;
`ifndef COUNT_CHECKER_WRAP_CNT_EN
    check("force_view_c2", bus.uo_out, 8'hC8);
`endif
    tick(1);
    #1;
`ifndef COUNT_CHECKER_WRAP_CNT_EN
    check("force_view_c0", bus.uo_out, 8'hC0);
`endif
    check("force_uio_out", bus.uio_out, 8'h60);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("force_err_cnt", bus.uo_out, 8'h02);

    // Stuck input: four consecutive mismatches end in FAIL, then clr recovers.
    tick(2);
    force_val = 8'h10;
    force_en = 1'b1;
    tick(3);
    #1;
    check("stuck_still_run", bus.uio_out, 8'h60);
    tick(1);
    #1;
    check("stuck_fail_uio", bus.uio_out, 8'hF0);
    check("stuck_err_cnt", bus.uo_out, 8'h06);
    tick(3);
    #1;
    check("stuck_fail_kept", bus.uio_out, 8'hF0);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    force_en = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("clr_uio_out", bus.uio_out, 8'h80);
    check("clr_err_cnt", bus.uo_out, 8'h00);

    // Restart, then hold with go dropped returns to IDLE.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
    tick(2);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    #1;
    check("hold_go_low_idle", bus.uio_out, 8'h80);

    // Reset mid-RUN with errors pending acts without a clock edge.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick(10);
    force_val = cnt_c + 8'd7;
    force_en = 1'b1;
    tick(1);
    force_en = 1'b0;
    tick(3);
    #1;
    check("pre_reset_err", bus.uo_out, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", bus.uo_out, 8'h00);
    check("async_rst_uio_out", bus.uio_out, 8'h80);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    #1;
    check("post_rst_sync", bus.uio_out, 8'h90);
    tick(20);
    #1;
    check("post_rst_run", bus.uio_out, 8'h20);
    check("post_rst_err", bus.uo_out, 8'h00);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
